seg7_display_ctrl: RTL and testbench

Parametrised N-digit seven-segment display controller for the board HEX displays. It replaces the fixed 8-digit, software-driven segment-register mapping.
- Holds per-digit hex values in local registers.
- Decodes values to segments in hardware.
- Adds per-digit blanking, timed blink and rotating scroll.
- Takes commands from the game/control logic over a valid/ready write port.

---
 rtl/seg7_display_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_seg7_display_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl -- N-digit seven-segment display controller.
//
// Holds one 5-bit value per digit ({blank, hex}), decodes it to segments and
// adds per-digit blink, rotating scroll and an optional leading-zero blanking
// stage. Commands arrive over a valid/ready write port; "clear all" runs a
// short FSM that blanks one digit per cycle.
//
// Ports:
//   CLOCK_50  system clock
//   reset     asynchronous reset, active-high
//   wr_valid  command valid; wr_ready high while the controller is idle
//   wr_cmd    00 write digit, 01 set blink mask, 10 set mode, 11 clear all
//   wr_addr   digit index for cmd 00 (indices >= NUM_DIGITS are ignored)
//   wr_data   cmd 00: [4]=blank,[3:0]=hex; cmd 01: mask; cmd 10: [0]=scroll
//   hex_out   registered segments, digit i at [7i+6:7i], bit0=a .. bit6=g
//
// Optional feature: define SEG7_LZB_EN for leading-zero blanking.

// Per-position decoder: hex font, blanking and output polarity.
module seg7_lane #(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [4:0] val,
    input  logic       dark,
    output logic [6:0] seg
);
    logic [6:0] lit;

    always_comb begin
        case (val[3:0])
            4'h0: lit = 7'h3F;
            4'h1: lit = 7'h06;
            4'h2: lit = 7'h5B;
            4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;
            4'h5: lit = 7'h6D;
            4'h6: lit = 7'h7D;
            4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;
            4'h9: lit = 7'h6F;
            4'hA: lit = 7'h77;
            4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39;
            4'hD: lit = 7'h5E;
            4'hE: lit = 7'h79;
            default: lit = 7'h71;
        endcase
        if (val[4] || dark) lit = 7'h00;
        seg = (ACTIVE_LOW != 0) ? ~lit : lit;
    end
endmodule

module seg7_display_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCROLL_DIV = 12500000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [1:0]              wr_cmd,
    input  logic [3:0]              wr_addr,
    input  logic [15:0]             wr_data,
    output logic [7*NUM_DIGITS-1:0] hex_out
);
    localparam int OW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(BLINK_DIV);
    localparam int SW = $clog2(SCROLL_DIV);
    localparam logic [4:0] BLANK = 5'h10;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                             state_q, state_d;
    logic [NUM_DIGITS-1:0][4:0]         digit_q, digit_d;
    logic [NUM_DIGITS-1:0]              mask_q, mask_d;
    logic                               scroll_q, scroll_d;
    logic [OW-1:0]                      offset_q, offset_d;
    logic [OW-1:0]                      clr_idx_q, clr_idx_d;
    logic                               phase_q, phase_d;
    logic [BW-1:0]                      blink_cnt_q, blink_cnt_d;
    logic [SW-1:0]                      scroll_cnt_q, scroll_cnt_d;
    logic [7*NUM_DIGITS-1:0]            hex_q, hex_d;

    logic                               accept;
    logic [NUM_DIGITS-1:0][4:0]         mapped;
    logic [NUM_DIGITS-1:0]              lzb_dark;
    logic [NUM_DIGITS-1:0]              lane_dark;
    logic [NUM_DIGITS-1:0][6:0]         seg_w;
    logic                               unused_wr_data;

    assign unused_wr_data = ^wr_data;
    assign accept         = wr_valid && wr_ready;

    // FSM: state register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && wr_cmd == 2'b11) state_d = CLEAR;
            CLEAR:   if (clr_idx_q == OW'(NUM_DIGITS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        wr_ready = (state_q == IDLE);
    end

    // Datapath next state. Command handling comes after the scroll step so
    // that disabling scroll forces the offset to 0 even on a wrap edge.
    always_comb begin
        digit_d      = digit_q;
        mask_d       = mask_q;
        scroll_d     = scroll_q;
        offset_d     = offset_q;
        clr_idx_d    = clr_idx_q;
        phase_d      = phase_q;
        blink_cnt_d  = blink_cnt_q + BW'(1);
        scroll_cnt_d = '0;

        if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        if (scroll_q) begin
            scroll_cnt_d = scroll_cnt_q + SW'(1);
            if (scroll_cnt_q == SW'(SCROLL_DIV - 1)) begin
                scroll_cnt_d = '0;
                offset_d = (offset_q == OW'(NUM_DIGITS - 1)) ? '0 : offset_q + OW'(1);
            end
        end

        if (accept) begin
            case (wr_cmd)
                2'b00: begin
                    // no index matches an out-of-range address, so it is dropped
                    for (int i = 0; i < NUM_DIGITS; i++)
                        if (wr_addr == 4'(i)) digit_d[i] = wr_data[4:0];
                end
                2'b01: mask_d = wr_data[NUM_DIGITS-1:0];
                2'b10: begin
                    scroll_d = wr_data[0];
                    if (!wr_data[0]) offset_d = '0;
                end
                default: begin
                    clr_idx_d = '0;
                    mask_d    = '0;
                    scroll_d  = 1'b0;
                    offset_d  = '0;
                end
            endcase
        end

        if (state_q == CLEAR) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                if (clr_idx_q == OW'(i)) digit_d[i] = BLANK;
            clr_idx_d = clr_idx_q + OW'(1);
        end
    end

    // Per-position scroll mapping, dark control and decode.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
        logic [OW:0]   sum;
        logic [OW-1:0] src;
        assign sum = (OW+1)'(g) + {1'b0, offset_q};
        assign src = (sum >= (OW+1)'(NUM_DIGITS)) ? OW'(sum - (OW+1)'(NUM_DIGITS))
                                                  : sum[OW-1:0];
        assign mapped[g]    = digit_q[src];
        assign lane_dark[g] = (phase_q && mask_q[g]) || lzb_dark[g];

        seg7_lane #(.ACTIVE_LOW(ACTIVE_LOW)) u_lane (
            .val  (mapped[g]),
            .dark (lane_dark[g]),
            .seg  (seg_w[g])
        );
    end

`ifdef SEG7_LZB_EN
    // Walk down from the top position; the run of dark zeros ends at the first
    // value that is not a plain zero. Position 0 is never part of the run.
    logic lzb_run;
    always_comb begin
        lzb_dark = '0;
        lzb_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lzb_run     = lzb_run && (mapped[i] == 5'h00);
            lzb_dark[i] = lzb_run;
        end
    end
`else
    assign lzb_dark = '0;
`endif

    always_comb begin
        hex_d = seg_w;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            digit_q      <= {NUM_DIGITS{BLANK}};
            mask_q       <= '0;
            scroll_q     <= 1'b0;
            offset_q     <= '0;
            clr_idx_q    <= '0;
            phase_q      <= 1'b0;
            blink_cnt_q  <= '0;
            scroll_cnt_q <= '0;
            hex_q        <= (ACTIVE_LOW != 0) ? '1 : '0;
        end else begin
            digit_q      <= digit_d;
            mask_q       <= mask_d;
            scroll_q     <= scroll_d;
            offset_q     <= offset_d;
            clr_idx_q    <= clr_idx_d;
            phase_q      <= phase_d;
            blink_cnt_q  <= blink_cnt_d;
            scroll_cnt_q <= scroll_cnt_d;
            hex_q        <= hex_d;
        end
    end

    assign hex_out = hex_q;
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl (8 digits, active-low, BLINK_DIV=4,
// SCROLL_DIV=3). Expected segment codes come from a hand-written font table.
module tb_seg7_display_ctrl;
    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_cmd   = '0;
    logic [3:0]  wr_addr  = '0;
    logic [15:0] wr_data  = '0;
    logic [55:0] hex_out;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [6:0]  DARK    = 7'h7F;
    localparam logic [55:0] ALLDARK = 56'hFF_FFFF_FFFF_FFFF;

    seg7_display_ctrl #(
        .NUM_DIGITS (8),
        .BLINK_DIV  (4),
        .SCROLL_DIV (3),
        .ACTIVE_LOW (1)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_cmd   (wr_cmd),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .hex_out  (hex_out)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // active-low segment code for a lit hex digit
    function automatic logic [6:0] sg(input logic [3:0] v);
        logic [6:0] l;
        case (v)
            4'h0: l = 7'h3F; 4'h1: l = 7'h06; 4'h2: l = 7'h5B; 4'h3: l = 7'h4F;
            4'h4: l = 7'h66; 4'h5: l = 7'h6D; 4'h6: l = 7'h7D; 4'h7: l = 7'h07;
            4'h8: l = 7'h7F; 4'h9: l = 7'h6F; 4'hA: l = 7'h77; 4'hB: l = 7'h7C;
            4'hC: l = 7'h39; 4'hD: l = 7'h5E; 4'hE: l = 7'h79; default: l = 7'h71;
        endcase
        return ~l;
    endfunction

    function automatic logic [6:0] pos(input int p);
        return hex_out[7*p +: 7];
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wr(input logic [1:0] c, input logic [3:0] a, input logic [15:0] d);
        wr_cmd   = c;
        wr_addr  = a;
        wr_data  = d;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        logic [55:0] e;
        int          low;
        bit          found;

        // reset state
        tick(); tick(); tick();
        chk("rst_hex", hex_out, ALLDARK);
        chk("rst_ready", wr_ready, 1);
        reset = 1'b0;
        tick();

        // digit writes and one-cycle output latency
        wr(2'b00, 4'd0, 16'h0003);
        chk("d0_latency", pos(0), DARK);
        tick();
        chk("d0_val3", pos(0), 7'h30);
        wr(2'b00, 4'd7, 16'h000A);
        tick();
        chk("d7_valA", pos(7), 7'h08);
        wr(2'b00, 4'd9, 16'h0005);
        tick(); tick();
        e = ALLDARK; e[6:0] = 7'h30; e[55:49] = 7'h08;
        chk("addr9_ignored", hex_out, e);

        // blink on position 0
        wr(2'b00, 4'd0, 16'h0008);
        wr(2'b01, 4'd0, 16'h0001);
        found = 0;
        for (int c = 0; c < 12; c++) begin
            if (pos(0) == DARK) begin found = 1; break; end
            tick();
        end
        chk("blink_dark_seen", found, 1);
        found = 0;
        for (int c = 0; c < 12; c++) begin
            if (pos(0) == 7'h00) begin found = 1; break; end
            tick();
        end
        chk("blink_lit_seen", found, 1);
        for (int c = 0; c < 12; c++) begin
            chk("blink_d0", pos(0), ((c / 4) % 2 == 0) ? 7'h00 : DARK);
            chk("blink_d7", pos(7), 7'h08);
            chk("blink_d3", pos(3), DARK);
            tick();
        end
        wr(2'b01, 4'd0, 16'h0000);
        tick();
        for (int c = 0; c < 6; c++) begin
            chk("unmask_d0", pos(0), 7'h00);
            tick();
        end

        // scroll
        for (int i = 0; i < 8; i++) wr(2'b00, 4'(i), 16'(i));
        tick();
        chk("scroll_pre", pos(0), sg(4'd0));
        wr(2'b10, 4'd0, 16'h0001);
        tick();
        chk("scroll_start", pos(0), sg(4'd0));
        for (int k = 1; k <= 9; k++) begin
            tick(); tick(); tick();
            chk("scroll_p0", pos(0), sg(4'(k % 8)));
            chk("scroll_p7", pos(7), sg(4'((k + 7) % 8)));
        end
        // offset is now 1; take two more steps so the mode-off effect is visible
        tick(); tick(); tick();
        tick(); tick(); tick();
        chk("scroll_p0_3", pos(0), sg(4'd3));
        wr(2'b10, 4'd0, 16'h0000);
        chk("scroll_off_latency", pos(0), sg(4'd3));
        tick();
        chk("scroll_off", pos(0), sg(4'd0));

        // clear all with a second command held while busy
        wr(2'b01, 4'd0, 16'h00FF);
        wr_cmd = 2'b11; wr_valid = 1'b1;
        tick();
        chk("clr_ready_drop", wr_ready, 0);
        wr_cmd = 2'b00; wr_addr = 4'd2; wr_data = 16'h0005;
        low = 0;
        while (!wr_ready && low < 20) begin
            low++;
            tick();
        end
        chk("clr_ready_low_cycles", low, 8);
        tick();
        wr_valid = 1'b0;
        chk("clr_all_dark", hex_out, ALLDARK);
        tick();
        e = ALLDARK; e[20:14] = sg(4'd5);
        chk("clr_held_write", hex_out, e);
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("clr_mask_cleared", pos(2), sg(4'd5));
        end

        // reset in the middle of a clear
        wr(2'b11, 4'd0, 16'h0000);
        tick(); tick();
        chk("midclr_busy", wr_ready, 0);
        reset = 1'b1;
        #1;
        chk("midclr_ready", wr_ready, 1);
        chk("midclr_hex", hex_out, ALLDARK);
        tick();
        reset = 1'b0;
        tick();
        chk("postrst_ready", wr_ready, 1);

        // leading zeros: digits 7..0 = 0,0,0,0,0,1,0,0
        for (int i = 0; i < 8; i++) wr(2'b00, 4'(i), (i == 2) ? 16'h0001 : 16'h0000);
        tick();
`ifdef SEG7_LZB_EN
        e = ALLDARK; e[20:14] = sg(4'd1); e[13:7] = sg(4'd0); e[6:0] = sg(4'd0);
`else
        e = {8{sg(4'd0)}}; e[20:14] = sg(4'd1);
`endif
        chk("lzb_100", hex_out, e);
        wr(2'b00, 4'd2, 16'h0000);
        tick();
`ifdef SEG7_LZB_EN
        e = ALLDARK; e[6:0] = sg(4'd0);
`else
        e = {8{sg(4'd0)}};
`endif
        chk("lzb_all_zero", hex_out, e);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
